// File: rtl/regfile_stream_loader_pkg.sv
// Shared types and constants for the register-file stream loader.
package regfile_stream_loader_pkg;

  localparam int unsigned ByteW = 8;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StFill  = 3'd1;
  localparam state_t StWrite = 3'd2;
  localparam state_t StCheck = 3'd3;
  localparam state_t StDone  = 3'd4;

  function automatic int unsigned bytes_of(input int unsigned width);
    return width / ByteW;
  endfunction

endpackage

// File: rtl/regfile_stream_loader_word_assembler.sv
// Little-endian byte-to-word assembler: byte index counter plus insert register.
module regfile_stream_loader_word_assembler
  import regfile_stream_loader_pkg::*;
#(
  parameter int unsigned DataW = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             byte_valid_i,
  input  logic [7:0]       byte_i,
  output logic             word_full_o,
  output logic [DataW-1:0] word_o
);

  localparam int unsigned Bytes = bytes_of(DataW);
  localparam int unsigned IdxW = (Bytes > 1) ? $clog2(Bytes) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Bytes - 1);

  logic [IdxW-1:0]  idx_q, idx_d;
  logic [DataW-1:0] word_q, word_d;

  // word_o carries the insert of the current byte so the top can latch it on the same edge
  always_comb begin
    idx_d       = idx_q;
    word_d      = word_q;
    word_full_o = byte_valid_i && (idx_q == LastIdx);
    if (clear_i) begin
      idx_d  = '0;
      word_d = '0;
    end else if (byte_valid_i) begin
      for (int unsigned b = 0; b < Bytes; b++) begin
        if (idx_q == IdxW'(b)) word_d[ByteW*b +: ByteW] = byte_i;
      end
      idx_d = word_full_o ? '0 : idx_q + 1'b1;
    end
  end

  assign word_o = word_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/regfile_stream_loader.sv
// Byte-stream to register-file write-port loader. Optional trailing XOR checksum
// check is enabled by defining LOADER_CHECKSUM_EN.
module regfile_stream_loader
  import regfile_stream_loader_pkg::*;
#(
  parameter int unsigned addr_width = 10,
  parameter int unsigned data_width = 32,
  parameter int unsigned lo         = 0,
  parameter int unsigned hi         = 1023
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic                  BYTE_VALID,
  input  logic [7:0]            BYTE_DATA,
  output logic                  BYTE_READY,
  output logic [addr_width-1:0] ADDR_IN,
  output logic [data_width-1:0] D_IN,
  output logic                  WE,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR
);

  localparam logic [addr_width-1:0] LoAddr = addr_width'(lo);
  localparam logic [addr_width-1:0] HiAddr = addr_width'(hi);

  state_t                  state_q, state_d;
  logic [addr_width-1:0]   addr_q;
  logic [data_width-1:0]   d_in_q;
  logic                    we_q;
  logic                    done_q;
  logic                    start_ok;
  logic                    fill_xfer;
  logic                    word_full;
  logic [data_width-1:0]   word;

  assign start_ok   = START && ((state_q == StIdle) || (state_q == StDone));
  assign BYTE_READY = (state_q == StFill) || (state_q == StCheck);
  assign BUSY       = (state_q == StFill) || (state_q == StWrite) || (state_q == StCheck);
  assign fill_xfer  = BYTE_VALID && (state_q == StFill);

  regfile_stream_loader_word_assembler #(
    .DataW (data_width)
  ) u_word_assembler (
    .clk_i        (CLK),
    .rst_ni       (RST_N),
    .clear_i      (start_ok),
    .byte_valid_i (fill_xfer),
    .byte_i       (BYTE_DATA),
    .word_full_o  (word_full),
    .word_o       (word)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone: if (start_ok) state_d = StFill;
      StFill:         if (fill_xfer && word_full) state_d = StWrite;
      StWrite: begin
        if (addr_q == HiAddr) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = StCheck;
`else
          state_d = StDone;
`endif
        end else begin
          state_d = StFill;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StCheck:        if (BYTE_VALID) state_d = StDone;
`endif
      default:        state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= StIdle;
      addr_q  <= '0;
      d_in_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= fill_xfer && word_full;
      done_q  <= (state_d == StDone);
      if (fill_xfer && word_full) d_in_q <= word;
      if (start_ok) begin
        addr_q <= LoAddr;
      end else if ((state_q == StWrite) && (addr_q != HiAddr)) begin
        addr_q <= addr_q + 1'b1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] acc_q;
  logic       err_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      acc_q <= '0;
      err_q <= 1'b0;
    end else if (start_ok) begin
      acc_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (fill_xfer) acc_q <= acc_q ^ BYTE_DATA;
      if (BYTE_VALID && (state_q == StCheck)) err_q <= ((acc_q ^ BYTE_DATA) != 8'h00);
    end
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  assign ADDR_IN = addr_q;
  assign D_IN    = d_in_q;
  assign WE      = we_q;
  assign DONE    = done_q;

endmodule

// File: tb/tb_regfile_stream_loader.sv
// Directed bench for regfile_stream_loader: a 32-bit lo=0/hi=3 instance and an
// 8-bit lo=5/hi=6 instance sharing clock and reset.
module tb_regfile_stream_loader;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic        start_a, valid_a, ready_a, we_a, busy_a, done_a, err_a;
  logic [7:0]  data_a;
  logic [9:0]  addr_a;
  logic [31:0] din_a;

  logic        start_b, valid_b, ready_b, we_b, busy_b, done_b, err_b;
  logic [7:0]  data_b;
  logic [9:0]  addr_b;
  logic [7:0]  din_b;

  logic [31:0] wd_a[$];
  logic [9:0]  wa_a[$];
  logic [7:0]  wd_b[$];
  logic [9:0]  wa_b[$];
  int          wc_b[$];

  localparam logic [31:0] ExpW0 = 32'h03020100;
  localparam logic [31:0] ExpW1 = 32'h07060504;
  localparam logic [31:0] ExpW2 = 32'h0B0A0908;
  localparam logic [31:0] ExpW3 = 32'h0F0E0D0C;
`ifdef LOADER_CHECKSUM_EN
  localparam int CsExtra = 1;
`else
  localparam int CsExtra = 0;
`endif

  regfile_stream_loader #(
    .addr_width (10),
    .data_width (32),
    .lo         (0),
    .hi         (3)
  ) u_dut_a (
    .CLK        (clk),
    .RST_N      (rst_n),
    .START      (start_a),
    .BYTE_VALID (valid_a),
    .BYTE_DATA  (data_a),
    .BYTE_READY (ready_a),
    .ADDR_IN    (addr_a),
    .D_IN       (din_a),
    .WE         (we_a),
    .BUSY       (busy_a),
    .DONE       (done_a),
    .ERR        (err_a)
  );

  regfile_stream_loader #(
    .addr_width (10),
    .data_width (8),
    .lo         (5),
    .hi         (6)
  ) u_dut_b (
    .CLK        (clk),
    .RST_N      (rst_n),
    .START      (start_b),
    .BYTE_VALID (valid_b),
    .BYTE_DATA  (data_b),
    .BYTE_READY (ready_b),
    .ADDR_IN    (addr_b),
    .D_IN       (din_b),
    .WE         (we_b),
    .BUSY       (busy_b),
    .DONE       (done_b),
    .ERR        (err_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we_a) begin
      wa_a.push_back(addr_a);
      wd_a.push_back(din_a);
    end
    if (we_b) begin
      wa_b.push_back(addr_b);
      wd_b.push_back(din_b);
      wc_b.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic s, input logic v, input logic [7:0] d);
    if (sel) begin
      start_b = s; valid_b = v; data_b = d;
    end else begin
      start_a = s; valid_a = v; data_a = d;
    end
  endtask

  // Called at a negedge; pulses START across one rising edge.
  task automatic do_start(input bit sel, output int t0);
    drive(sel, 1'b1, 1'b0, 8'h00);
    @(posedge clk);
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 8'h00);
    t0 = cyc;
    chk("start_busy",  32'(sel ? busy_b  : busy_a),  32'd1);
    chk("start_ready", 32'(sel ? ready_b : ready_a), 32'd1);
    chk("start_done_clr", 32'(sel ? done_b : done_a), 32'd0);
  endtask

  // Sends n bytes base, base+1, ...; optional stall and stray START pulse.
  task automatic stream(input bit sel, input int n, input logic [7:0] base,
                        input int stall_after, input int stall_len, input int start_at);
    int   sent = 0;
    int   stalled = 0;
    int   budget = 0;
    logic rdy;
    logic v;
    while (sent < n && budget < 500) begin
      rdy = sel ? ready_b : ready_a;
      v = 1'b1;
      if (sent == stall_after && stalled < stall_len) begin
        v = 1'b0;
        stalled++;
      end
      drive(sel, (sent == start_at), v, 8'(base + 8'(sent)));
      @(posedge clk);
      budget++;
      if (v && rdy) sent++;
      @(negedge clk);
    end
    drive(sel, 1'b0, 1'b0, 8'h00);
    chk("stream_budget", 32'(sent), 32'(n));
  endtask

  task automatic load_a(input int stall_after, input int stall_len, input int start_at,
                        input logic [7:0] cs);
    stream(1'b0, 16, 8'h00, stall_after, stall_len, start_at);
`ifdef LOADER_CHECKSUM_EN
    stream(1'b0, 1, cs, -1, 0, -1);
`else
    chk("cs_unused", 32'(cs), 32'(cs & 8'h00));
`endif
  endtask

  task automatic wait_done(input bit sel, output int t);
    int b = 0;
    while (!(sel ? done_b : done_a) && b < 200) begin
      @(negedge clk);
      b++;
    end
    chk("done_seen", 32'(sel ? done_b : done_a), 32'd1);
    t = cyc;
  endtask

  task automatic check_words_a(input string tag);
    chk({tag, "_count"}, 32'(wd_a.size()), 32'd4);
    chk({tag, "_a0"}, 32'(wa_a[0]), 32'd0);
    chk({tag, "_a1"}, 32'(wa_a[1]), 32'd1);
    chk({tag, "_a2"}, 32'(wa_a[2]), 32'd2);
    chk({tag, "_a3"}, 32'(wa_a[3]), 32'd3);
    chk({tag, "_d0"}, wd_a[0], ExpW0);
    chk({tag, "_d1"}, wd_a[1], ExpW1);
    chk({tag, "_d2"}, wd_a[2], ExpW2);
    chk({tag, "_d3"}, wd_a[3], ExpW3);
  endtask

  initial begin
    int t0, t1;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready_a), 32'd0);
    chk("rst_we",    32'(we_a),    32'd0);
    chk("rst_addr",  32'(addr_a),  32'd0);
    chk("rst_din",   din_a,        32'd0);
    chk("rst_busy",  32'(busy_a),  32'd0);
    chk("rst_done",  32'(done_a),  32'd0);
    chk("rst_err",   32'(err_a),   32'd0);
    chk("rst_b_din", 32'(din_b),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic load, VALID always high.
    wd_a.delete(); wa_a.delete();
    do_start(1'b0, t0);
    load_a(-1, 0, -1, 8'h00);
    wait_done(1'b0, t1);
    chk("t1_latency", 32'(t1 - t0), 32'(20 + CsExtra));
    chk("t1_err", 32'(err_a), 32'd0);
    check_words_a("t1");

    // Five-cycle stall after the second byte.
    wd_a.delete(); wa_a.delete();
    do_start(1'b0, t0);
    load_a(2, 5, -1, 8'h00);
    wait_done(1'b0, t1);
    chk("t2_latency", 32'(t1 - t0), 32'(25 + CsExtra));
    check_words_a("t2");

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum byte.
    wd_a.delete(); wa_a.delete();
    do_start(1'b0, t0);
    load_a(-1, 0, -1, 8'h01);
    wait_done(1'b0, t1);
    chk("t3_err", 32'(err_a), 32'd1);
    check_words_a("t3");
`endif

    // Stray START while busy.
    wd_a.delete(); wa_a.delete();
    do_start(1'b0, t0);
    load_a(-1, 0, 5, 8'h00);
    wait_done(1'b0, t1);
    chk("t5_latency", 32'(t1 - t0), 32'(20 + CsExtra));
    chk("t5_err", 32'(err_a), 32'd0);
    check_words_a("t5");

    // Reset after the sixth byte, then reload.
    wd_a.delete(); wa_a.delete();
    do_start(1'b0, t0);
    stream(1'b0, 6, 8'h00, -1, 0, -1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("t4_we",    32'(we_a),    32'd0);
    chk("t4_busy",  32'(busy_a),  32'd0);
    chk("t4_ready", 32'(ready_a), 32'd0);
    chk("t4_done",  32'(done_a),  32'd0);
    repeat (6) @(negedge clk);
    chk("t4_wcount", 32'(wd_a.size()), 32'd1);
    chk("t4_w0", wd_a[0], ExpW0);
    wd_a.delete(); wa_a.delete();
    do_start(1'b0, t0);
    load_a(-1, 0, -1, 8'h00);
    wait_done(1'b0, t1);
    check_words_a("t4r");

    // 8-bit words, lo=5, hi=6.
    do_start(1'b1, t0);
    stream(1'b1, 1, 8'hAA, -1, 0, -1);
    stream(1'b1, 1, 8'h55, -1, 0, -1);
`ifdef LOADER_CHECKSUM_EN
    stream(1'b1, 1, 8'hFF, -1, 0, -1);
`endif
    wait_done(1'b1, t1);
    chk("t6_latency", 32'(t1 - t0), 32'(4 + CsExtra));
    chk("t6_count", 32'(wd_b.size()), 32'd2);
    chk("t6_a0", 32'(wa_b[0]), 32'd5);
    chk("t6_a1", 32'(wa_b[1]), 32'd6);
    chk("t6_d0", 32'(wd_b[0]), 32'h0000_00AA);
    chk("t6_d1", 32'(wd_b[1]), 32'h0000_0055);
    chk("t6_spacing", 32'(wc_b[1] - wc_b[0]), 32'd2);
    chk("t6_err", 32'(err_b), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
